key_entry_ctrl: RTL and testbench

KEY_ENTRY_CTRL -- requirements
Module: key_entry_ctrl

---
 rtl/key_entry_ctrl_pkg.sv | 51 +++++
 rtl/key_entry_ctrl_debounce.sv | 104 ++++++++++
 rtl/key_entry_ctrl.sv | 129 ++++++++++++
 tb/tb_key_entry_ctrl.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/key_entry_ctrl_pkg.sv
// Shared definitions for the keypad entry controller: FSM encoding, key codes
// and operator encodings, plus small key-decoding helpers.
package key_entry_ctrl_pkg;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_PRESS_DEB = 2'd1;
    localparam logic [1:0] ST_HELD      = 2'd2;
    localparam logic [1:0] ST_REL_DEB   = 2'd3;

    localparam logic [3:0] KEY_DIGIT_MAX = 4'h9;
    localparam logic [3:0] KEY_OP_FIRST  = 4'hA;
    localparam logic [3:0] KEY_CLR       = 4'hE;
    localparam logic [3:0] KEY_EQ        = 4'hF;

    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_MUL = 2'd2;
    localparam logic [1:0] OP_DIV = 2'd3;

    typedef enum logic [1:0] {
        KEY_DIGIT,
        KEY_OPER,
        KEY_CLEAR,
        KEY_EQUAL
    } key_class_e;

    function automatic key_class_e classify(input logic [3:0] k);
        key_class_e c;
        if (k <= KEY_DIGIT_MAX)
            c = KEY_DIGIT;
        else if (k >= KEY_OP_FIRST && k < KEY_CLR)
            c = KEY_OPER;
        else if (k == KEY_CLR)
            c = KEY_CLEAR;
        else
            c = KEY_EQUAL;
        return c;
    endfunction

    function automatic logic [1:0] op_of_key(input logic [3:0] k);
        logic [1:0] op;
        case (k)
            4'hA:    op = OP_ADD;
            4'hB:    op = OP_SUB;
            4'hC:    op = OP_MUL;
            default: op = OP_DIV;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/key_entry_ctrl_debounce.sv
// Press/release debouncer for the keypad: four-state FSM with a saturating
// counter; emits a single-cycle accept strobe plus the latched key code.
module key_debounce
    import key_entry_ctrl_pkg::*;
#(
    parameter int DEB_CYCLES = 16
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       ENABLE,
    input  logic       KEY_VALID,
    input  logic [3:0] KEY_CODE,
    output logic       accept,
    output logic [3:0] key_code
);

    localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);

    logic [1:0]       state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [3:0]       code_reg, code_next;
    // A key that is down across a reset or a disable must be released before it counts again.
    logic             wait_release_reg, wait_release_next;

    always_comb begin
        state_next        = state_reg;
        cnt_next          = cnt_reg;
        code_next         = code_reg;
        accept            = 1'b0;
        wait_release_next = wait_release_reg;

        if (!KEY_VALID)
            wait_release_next = 1'b0;
        else if (!ENABLE)
            wait_release_next = 1'b1;

        if (!ENABLE) begin
            state_next = ST_IDLE;
            cnt_next   = '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (KEY_VALID && !wait_release_reg) begin
                        state_next = ST_PRESS_DEB;
                        cnt_next   = '0;
                        code_next  = KEY_CODE;
                    end
                end
                ST_PRESS_DEB: begin
                    if (!KEY_VALID) begin
                        state_next = ST_IDLE;
                        cnt_next   = '0;
                    end else if (KEY_CODE != code_reg) begin
                        code_next = KEY_CODE;
                        cnt_next  = '0;
                    end else if (cnt_reg == CNT_MAX) begin
                        state_next = ST_HELD;
                        accept     = 1'b1;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
                ST_HELD: begin
                    if (!KEY_VALID) begin
                        state_next = ST_REL_DEB;
                        cnt_next   = '0;
                    end
                end
                ST_REL_DEB: begin
                    if (KEY_VALID) begin
                        state_next = ST_HELD;
                    end else if (cnt_reg == CNT_MAX) begin
                        state_next = ST_IDLE;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                    cnt_next   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_reg        <= ST_IDLE;
            cnt_reg          <= '0;
            code_reg         <= '0;
            wait_release_reg <= 1'b1;
        end else begin
            state_reg        <= state_next;
            cnt_reg          <= cnt_next;
            code_reg         <= code_next;
            wait_release_reg <= wait_release_next;
        end
    end

    assign key_code = code_reg;

endmodule

// File: rtl/key_entry_ctrl.sv
// Calculator key entry: debounced keypad presses build a packed BCD operand and
// produce operator / equals strobes carrying the operand.
module key_entry_ctrl
    import key_entry_ctrl_pkg::*;
#(
    parameter int DEB_CYCLES = 16,
    parameter int NDIG       = 4
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              ENABLE,
    input  logic              KEY_VALID,
    input  logic [3:0]        KEY_CODE,
    output logic              KB_EN,
    output logic [4*NDIG-1:0] OPERAND,
    output logic [2:0]        DIGIT_CNT,
    output logic [1:0]        OP_CODE,
    output logic              OP_VALID,
    output logic              EQ_VALID,
    output logic              OVF
);

    localparam logic [2:0] NDIG_CNT = 3'(NDIG);

    logic              accept;
    logic [3:0]        key_code;
    key_class_e        key_class;

    logic              enable_reg;
    logic [4*NDIG-1:0] operand_reg, operand_next, operand_shift;
    logic [2:0]        digit_cnt_reg, digit_cnt_next;
    logic [1:0]        op_code_reg, op_code_next;
    logic              op_valid_reg, op_valid_next;
    logic              eq_valid_reg, eq_valid_next;
    logic              ovf_reg, ovf_next;

    key_debounce #(
        .DEB_CYCLES(DEB_CYCLES)
    ) u_debounce (
        .CLK      (CLK),
        .RESET    (RESET),
        .ENABLE   (ENABLE),
        .KEY_VALID(KEY_VALID),
        .KEY_CODE (KEY_CODE),
        .accept   (accept),
        .key_code (key_code)
    );

    assign key_class = classify(key_code);

    // New digit enters at the least-significant nibble; the top nibble falls off.
    assign operand_shift[3:0] = key_code;
    genvar gi;
    generate
        for (gi = 1; gi < NDIG; gi++) begin : g_shift
            assign operand_shift[4*gi +: 4] = operand_reg[4*(gi-1) +: 4];
        end
    endgenerate

    always_comb begin
        operand_next   = operand_reg;
        digit_cnt_next = digit_cnt_reg;
        op_code_next   = op_code_reg;
        ovf_next       = ovf_reg;
        op_valid_next  = 1'b0;
        eq_valid_next  = 1'b0;

        // The operand stays visible for the strobe cycle, then clears.
        if (op_valid_reg || eq_valid_reg) begin
            operand_next   = '0;
            digit_cnt_next = '0;
        end

        if (accept) begin
            case (key_class)
                KEY_DIGIT: begin
                    if (digit_cnt_reg < NDIG_CNT) begin
                        operand_next   = operand_shift;
                        digit_cnt_next = digit_cnt_reg + 3'd1;
                    end else begin
                        ovf_next = 1'b1;
                    end
                end
                KEY_OPER: begin
                    op_code_next  = op_of_key(key_code);
                    op_valid_next = 1'b1;
                end
                KEY_EQUAL: begin
                    eq_valid_next = 1'b1;
                end
                default: begin
                    operand_next   = '0;
                    digit_cnt_next = '0;
                    op_code_next   = OP_ADD;
                    ovf_next       = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            enable_reg    <= 1'b0;
            operand_reg   <= '0;
            digit_cnt_reg <= '0;
            op_code_reg   <= '0;
            op_valid_reg  <= 1'b0;
            eq_valid_reg  <= 1'b0;
            ovf_reg       <= 1'b0;
        end else begin
            enable_reg    <= ENABLE;
            operand_reg   <= operand_next;
            digit_cnt_reg <= digit_cnt_next;
            op_code_reg   <= op_code_next;
            op_valid_reg  <= op_valid_next;
            eq_valid_reg  <= eq_valid_next;
            ovf_reg       <= ovf_next;
        end
    end

    assign KB_EN     = enable_reg;
    assign OPERAND   = operand_reg;
    assign DIGIT_CNT = digit_cnt_reg;
    assign OP_CODE   = op_code_reg;
    assign OP_VALID  = op_valid_reg;
    assign EQ_VALID  = eq_valid_reg;
    assign OVF       = ovf_reg;

endmodule

// File: tb/tb_key_entry_ctrl.sv
// Directed self-checking bench for key_entry_ctrl with DEB_CYCLES = 4, NDIG = 4.
module tb_key_entry_ctrl;

    logic        CLK;
    logic        RESET;
    logic        ENABLE;
    logic        KEY_VALID;
    logic [3:0]  KEY_CODE;
    logic        KB_EN;
    logic [15:0] OPERAND;
    logic [2:0]  DIGIT_CNT;
    logic [1:0]  OP_CODE;
    logic        OP_VALID;
    logic        EQ_VALID;
    logic        OVF;

    int checks = 0;
    int errors = 0;

    // Pulse monitor state
    int          op_count   = 0;
    int          eq_count   = 0;
    int          both_count = 0;
    logic [15:0] cap_op_operand;
    logic [1:0]  cap_op_code;
    logic [15:0] cap_eq_operand;
    logic [15:0] after_operand;
    logic        pulse_prev = 1'b0;

    key_entry_ctrl #(
        .DEB_CYCLES(4),
        .NDIG      (4)
    ) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .ENABLE   (ENABLE),
        .KEY_VALID(KEY_VALID),
        .KEY_CODE (KEY_CODE),
        .KB_EN    (KB_EN),
        .OPERAND  (OPERAND),
        .DIGIT_CNT(DIGIT_CNT),
        .OP_CODE  (OP_CODE),
        .OP_VALID (OP_VALID),
        .EQ_VALID (EQ_VALID),
        .OVF      (OVF)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (pulse_prev)
            after_operand <= OPERAND;
        pulse_prev <= OP_VALID | EQ_VALID;
        if (OP_VALID) begin
            op_count       <= op_count + 1;
            cap_op_operand <= OPERAND;
            cap_op_code    <= OP_CODE;
        end
        if (EQ_VALID) begin
            eq_count       <= eq_count + 1;
            cap_eq_operand <= OPERAND;
        end
        if (OP_VALID && EQ_VALID)
            both_count <= both_count + 1;
    end

    task automatic step(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic press(input logic [3:0] code, input int hold, input int rel);
        KEY_CODE  = code;
        KEY_VALID = 1'b1;
        step(hold);
        KEY_VALID = 1'b0;
        KEY_CODE  = 4'h0;
        step(rel);
    endtask

    task automatic test_reset();
        RESET = 1'b1; ENABLE = 1'b1; KEY_VALID = 1'b0; KEY_CODE = 4'h0;
        step(3);
        checks++; if (OPERAND !== 16'h0) begin errors++; $display("FAIL reset_operand: got %h want 0000", OPERAND); end
        checks++; if (DIGIT_CNT !== 3'd0) begin errors++; $display("FAIL reset_digit_cnt: got %0d want 0", DIGIT_CNT); end
        checks++; if (OP_CODE !== 2'd0) begin errors++; $display("FAIL reset_op_code: got %0d want 0", OP_CODE); end
        checks++; if (OP_VALID !== 1'b0) begin errors++; $display("FAIL reset_op_valid: got %b want 0", OP_VALID); end
        checks++; if (EQ_VALID !== 1'b0) begin errors++; $display("FAIL reset_eq_valid: got %b want 0", EQ_VALID); end
        checks++; if (OVF !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", OVF); end
        checks++; if (KB_EN !== 1'b0) begin errors++; $display("FAIL reset_kb_en: got %b want 0", KB_EN); end
        RESET = 1'b0;
        step(2);
        checks++; if (KB_EN !== 1'b1) begin errors++; $display("FAIL kb_en_follow: got %b want 1", KB_EN); end
        $display("test_reset done");
    endtask

    task automatic test_digits();
        press(4'h1, 10, 10);
        press(4'h2, 10, 10);
        press(4'h3, 10, 10);
        checks++; if (OPERAND !== 16'h0123) begin errors++; $display("FAIL digits_operand: got %h want 0123", OPERAND); end
        checks++; if (DIGIT_CNT !== 3'd3) begin errors++; $display("FAIL digits_cnt: got %0d want 3", DIGIT_CNT); end
        checks++; if (op_count !== 0) begin errors++; $display("FAIL digits_op_pulses: got %0d want 0", op_count); end
        checks++; if (eq_count !== 0) begin errors++; $display("FAIL digits_eq_pulses: got %0d want 0", eq_count); end
        $display("test_digits: operand=%h cnt=%0d", OPERAND, DIGIT_CNT);
    endtask

    task automatic test_operator();
        int op0;
        press(4'hE, 10, 10);
        op0 = op_count;
        press(4'h4, 10, 10);
        press(4'h2, 10, 10);
        press(4'hB, 10, 10);
        checks++; if (op_count - op0 !== 1) begin errors++; $display("FAIL oper_pulse_count: got %0d want 1", op_count - op0); end
        checks++; if (cap_op_operand !== 16'h0042) begin errors++; $display("FAIL oper_operand: got %h want 0042", cap_op_operand); end
        checks++; if (cap_op_code !== 2'd1) begin errors++; $display("FAIL oper_code: got %0d want 1", cap_op_code); end
        checks++; if (after_operand !== 16'h0) begin errors++; $display("FAIL oper_after_clear: got %h want 0000", after_operand); end
        checks++; if (DIGIT_CNT !== 3'd0) begin errors++; $display("FAIL oper_cnt_clear: got %0d want 0", DIGIT_CNT); end
        $display("test_operator: captured operand=%h op=%0d", cap_op_operand, cap_op_code);
    endtask

    task automatic test_equals();
        int op0, eq0;
        op0 = op_count;
        eq0 = eq_count;
        press(4'h7, 10, 10);
        press(4'hF, 10, 10);
        checks++; if (eq_count - eq0 !== 1) begin errors++; $display("FAIL eq_pulse_count: got %0d want 1", eq_count - eq0); end
        checks++; if (op_count - op0 !== 0) begin errors++; $display("FAIL eq_no_op_pulse: got %0d want 0", op_count - op0); end
        checks++; if (cap_eq_operand !== 16'h0007) begin errors++; $display("FAIL eq_operand: got %h want 0007", cap_eq_operand); end
        checks++; if (after_operand !== 16'h0) begin errors++; $display("FAIL eq_after_clear: got %h want 0000", after_operand); end
        press(4'hC, 10, 10);
        checks++; if (op_count - op0 !== 1) begin errors++; $display("FAIL op_empty_pulse: got %0d want 1", op_count - op0); end
        checks++; if (cap_op_operand !== 16'h0) begin errors++; $display("FAIL op_empty_operand: got %h want 0000", cap_op_operand); end
        checks++; if (OP_CODE !== 2'd2) begin errors++; $display("FAIL op_empty_code: got %0d want 2", OP_CODE); end
        $display("test_equals: eq operand=%h op_code=%0d", cap_eq_operand, OP_CODE);
    endtask

    task automatic test_overflow_clear();
        for (int k = 1; k <= 5; k++) begin
            logic [3:0] d;
            d = 4'(k);
            press(d, 10, 10);
        end
        checks++; if (OPERAND !== 16'h1234) begin errors++; $display("FAIL ovf_operand: got %h want 1234", OPERAND); end
        checks++; if (DIGIT_CNT !== 3'd4) begin errors++; $display("FAIL ovf_cnt: got %0d want 4", DIGIT_CNT); end
        checks++; if (OVF !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b want 1", OVF); end
        press(4'hE, 10, 10);
        checks++; if (OPERAND !== 16'h0) begin errors++; $display("FAIL clr_operand: got %h want 0000", OPERAND); end
        checks++; if (DIGIT_CNT !== 3'd0) begin errors++; $display("FAIL clr_cnt: got %0d want 0", DIGIT_CNT); end
        checks++; if (OP_CODE !== 2'd0) begin errors++; $display("FAIL clr_op_code: got %0d want 0", OP_CODE); end
        checks++; if (OVF !== 1'b0) begin errors++; $display("FAIL clr_ovf: got %b want 0", OVF); end
        $display("test_overflow_clear: operand=%h ovf=%b", OPERAND, OVF);
    endtask

    task automatic test_glitch_and_long_hold();
        press(4'h5, 2, 10);
        checks++; if (DIGIT_CNT !== 3'd0) begin errors++; $display("FAIL glitch_cnt: got %0d want 0", DIGIT_CNT); end
        checks++; if (OPERAND !== 16'h0) begin errors++; $display("FAIL glitch_operand: got %h want 0000", OPERAND); end
        press(4'h5, 200, 10);
        checks++; if (DIGIT_CNT !== 3'd1) begin errors++; $display("FAIL long_hold_cnt: got %0d want 1", DIGIT_CNT); end
        checks++; if (OPERAND !== 16'h0005) begin errors++; $display("FAIL long_hold_operand: got %h want 0005", OPERAND); end
        $display("test_glitch_and_long_hold: operand=%h cnt=%0d", OPERAND, DIGIT_CNT);
    endtask

    task automatic test_release_glitch();
        KEY_CODE = 4'h6; KEY_VALID = 1'b1; step(10);
        KEY_VALID = 1'b0; step(2);
        KEY_VALID = 1'b1; step(10);
        KEY_VALID = 1'b0; step(10);
        checks++; if (DIGIT_CNT !== 3'd2) begin errors++; $display("FAIL rel_glitch_cnt: got %0d want 2", DIGIT_CNT); end
        checks++; if (OPERAND !== 16'h0056) begin errors++; $display("FAIL rel_glitch_operand: got %h want 0056", OPERAND); end
        $display("test_release_glitch: operand=%h cnt=%0d", OPERAND, DIGIT_CNT);
    endtask

    task automatic test_reset_mid_press();
        KEY_CODE = 4'h7; KEY_VALID = 1'b1;
        step(2);
        RESET = 1'b1; step(1);
        RESET = 1'b0; step(20);
        checks++; if (DIGIT_CNT !== 3'd0) begin errors++; $display("FAIL rst_mid_cnt: got %0d want 0", DIGIT_CNT); end
        checks++; if (OPERAND !== 16'h0) begin errors++; $display("FAIL rst_mid_operand: got %h want 0000", OPERAND); end
        KEY_VALID = 1'b0; step(10);
        press(4'h7, 10, 10);
        checks++; if (DIGIT_CNT !== 3'd1) begin errors++; $display("FAIL rst_repress_cnt: got %0d want 1", DIGIT_CNT); end
        checks++; if (OPERAND !== 16'h0007) begin errors++; $display("FAIL rst_repress_operand: got %h want 0007", OPERAND); end
        $display("test_reset_mid_press: operand=%h cnt=%0d", OPERAND, DIGIT_CNT);
    endtask

    task automatic test_enable_drop();
        KEY_CODE = 4'h8; KEY_VALID = 1'b1; step(10);
        ENABLE = 1'b0; step(3);
        KEY_VALID = 1'b0; step(5);
        checks++; if (KB_EN !== 1'b0) begin errors++; $display("FAIL dis_kb_en: got %b want 0", KB_EN); end
        checks++; if (OPERAND !== 16'h0078) begin errors++; $display("FAIL dis_operand_kept: got %h want 0078", OPERAND); end
        checks++; if (DIGIT_CNT !== 3'd2) begin errors++; $display("FAIL dis_cnt_kept: got %0d want 2", DIGIT_CNT); end
        press(4'h3, 10, 10);
        checks++; if (DIGIT_CNT !== 3'd2) begin errors++; $display("FAIL dis_press_ignored: got %0d want 2", DIGIT_CNT); end
        ENABLE = 1'b1; step(2);
        press(4'h9, 10, 10);
        checks++; if (OPERAND !== 16'h0789) begin errors++; $display("FAIL reen_operand: got %h want 0789", OPERAND); end
        $display("test_enable_drop: operand=%h cnt=%0d", OPERAND, DIGIT_CNT);
    endtask

    initial begin
        RESET = 1'b1; ENABLE = 1'b0; KEY_VALID = 1'b0; KEY_CODE = 4'h0;
        step(1);
        test_reset();
        test_digits();
        test_operator();
        test_equals();
        test_overflow_clear();
        test_glitch_and_long_hold();
        test_release_glitch();
        test_reset_mid_press();
        test_enable_drop();
        checks++; if (both_count !== 0) begin errors++; $display("FAIL pulses_exclusive: got %0d overlaps want 0", both_count); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
